// File: rtl/mem_access_if.sv
// Data-memory req/ack handshake between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: owns the EX/MEM and MEM/WB registers,
// performs word loads/stores over the req/ack data-memory handshake,
// resolves branches/jumps and stalls the front end on slow memory.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  EX_ALU_result,
  input  logic         EX_zero,
  input  logic [4:0]   EX_rd,
  input  logic         EX_branch,
  input  logic         EX_unconditional_jmp,
  input  logic         EX_memread,
  input  logic         EX_memwrite,
  input  logic         EX_memtoreg,
  input  logic         EX_regwrite,
  input  logic [31:0]  EX_rs2_data,
  input  logic [31:0]  EX_pc,
  input  logic         EX_stall,
  mem_access_if.master dmem,
  output logic [31:0]  EX_MEM_ALU_result,
  output logic [4:0]   EX_MEM_rd,
  output logic         EX_MEM_regwrite,
  output logic         EX_MEM_memread,
  output logic         EX_MEM_memtoreg,
  output logic [31:0]  EX_MEM_pc,
  output logic [31:0]  MEM_WB_result,
  output logic [4:0]   MEM_WB_rd,
  output logic         MEM_WB_regwrite,
  output logic         MEM_stall,
  output logic         MEM_take,
  output logic         MEM_misaligned,
  output logic [31:0]  MEM_wait_cycles
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic        ex_mem_zero;
  logic        ex_mem_branch;
  logic        ex_mem_jmp;
  logic        ex_mem_memwrite;
  logic [31:0] ex_mem_rs2_data;
  logic        mem_op;
  logic        misaligned;
  logic        bubble;
  logic        unused_in_wait;

  assign mem_op     = EX_MEM_memread | ex_mem_memwrite;
  assign misaligned = mem_op & (EX_MEM_ALU_result[1:0] != 2'b00);

  assign dmem.dmem_req   = mem_op & ~misaligned;
  assign dmem.dmem_we    = ex_mem_memwrite;
  assign dmem.dmem_addr  = EX_MEM_ALU_result;
  assign dmem.dmem_wdata = ex_mem_rs2_data;

  assign MEM_stall = dmem.dmem_req & ~dmem.dmem_ack;
  assign MEM_take  = ~MEM_stall & (ex_mem_jmp | (ex_mem_branch & ex_mem_zero));
  assign bubble    = EX_stall | MEM_take;

  // Transfer phase is tracked for observability only; the datapath keys
  // directly off dmem_req/dmem_ack.
  assign unused_in_wait = (state == ST_WAIT);

  // EX/MEM register: capture execute results, inject bubble on load-use
  // stall or taken control flow, hold while memory stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_ALU_result <= '0;
      ex_mem_zero       <= 1'b0;
      EX_MEM_rd         <= '0;
      ex_mem_branch     <= 1'b0;
      ex_mem_jmp        <= 1'b0;
      EX_MEM_memread    <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      EX_MEM_memtoreg   <= 1'b0;
      EX_MEM_regwrite   <= 1'b0;
      ex_mem_rs2_data   <= '0;
      EX_MEM_pc         <= '0;
    end else if (!MEM_stall) begin
      EX_MEM_ALU_result <= EX_ALU_result;
      ex_mem_zero       <= EX_zero;
      EX_MEM_rd         <= EX_rd;
      ex_mem_branch     <= EX_branch & ~bubble;
      ex_mem_jmp        <= EX_unconditional_jmp & ~bubble;
      EX_MEM_memread    <= EX_memread & ~bubble;
      ex_mem_memwrite   <= EX_memwrite & ~bubble;
      EX_MEM_memtoreg   <= EX_memtoreg;
      EX_MEM_regwrite   <= EX_regwrite & ~bubble;
      ex_mem_rs2_data   <= EX_rs2_data;
      EX_MEM_pc         <= EX_pc;
    end
  end

  // MEM/WB register: retire one op per unstalled edge, bubble while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_WB_result   <= '0;
      MEM_WB_rd       <= '0;
      MEM_WB_regwrite <= 1'b0;
    end else if (!MEM_stall) begin
      MEM_WB_result   <= EX_MEM_memtoreg ? dmem.dmem_rdata : EX_MEM_ALU_result;
      MEM_WB_rd       <= EX_MEM_rd;
      MEM_WB_regwrite <= EX_MEM_regwrite & ~misaligned;
    end else begin
      MEM_WB_regwrite <= 1'b0;
    end
  end

  // Sticky misaligned flag and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_misaligned  <= 1'b0;
      MEM_wait_cycles <= '0;
    end else begin
      if (misaligned) begin
        MEM_misaligned <= 1'b1;
      end
      if (MEM_stall && (MEM_wait_cycles != '1)) begin
        MEM_wait_cycles <= MEM_wait_cycles + 32'd1;
      end
    end
  end

  // Request phase FSM: WAIT while a request has been outstanding over an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (dmem.dmem_req && !dmem.dmem_ack) state <= ST_WAIT;
        ST_WAIT: if (dmem.dmem_ack) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by random
// instruction streams against a program-order reference model.
module tb_mem_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] EX_ALU_result, EX_rs2_data, EX_pc;
  logic        EX_zero, EX_branch, EX_unconditional_jmp;
  logic        EX_memread, EX_memwrite, EX_memtoreg, EX_regwrite, EX_stall;
  logic [4:0]  EX_rd;
  logic [31:0] EX_MEM_ALU_result, EX_MEM_pc, MEM_WB_result, MEM_wait_cycles;
  logic [4:0]  EX_MEM_rd, MEM_WB_rd;
  logic        EX_MEM_regwrite, EX_MEM_memread, EX_MEM_memtoreg;
  logic        MEM_WB_regwrite, MEM_stall, MEM_take, MEM_misaligned;

  mem_access_if dmem_bus ();

  mem_access dut (
    .clk(clk), .rst(rst),
    .EX_ALU_result(EX_ALU_result), .EX_zero(EX_zero), .EX_rd(EX_rd),
    .EX_branch(EX_branch), .EX_unconditional_jmp(EX_unconditional_jmp),
    .EX_memread(EX_memread), .EX_memwrite(EX_memwrite),
    .EX_memtoreg(EX_memtoreg), .EX_regwrite(EX_regwrite),
    .EX_rs2_data(EX_rs2_data), .EX_pc(EX_pc), .EX_stall(EX_stall),
    .dmem(dmem_bus),
    .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memtoreg(EX_MEM_memtoreg), .EX_MEM_pc(EX_MEM_pc),
    .MEM_WB_result(MEM_WB_result), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_regwrite(MEM_WB_regwrite), .MEM_stall(MEM_stall),
    .MEM_take(MEM_take), .MEM_misaligned(MEM_misaligned),
    .MEM_wait_cycles(MEM_wait_cycles)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        zero, br, jmp, mr, mw, m2r, rw, stall;
  } instr_t;
  typedef struct packed { logic [31:0] result; logic [4:0] rd; } ret_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mop_t;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  instr_t      cur, stg;
  bit          stg_eff, consumed, busy, mis_model, nop_fill;
  int unsigned rem;
  logic [31:0] hold_addr, exp_wait, pc_ctr;
  ret_t        exp_ret[$];
  mop_t        exp_mop[$];
  instr_t      dq[$];
  int unsigned lq[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_val(a);
  endfunction

  function automatic bit is_mis(input instr_t i);
    return (i.mr || i.mw) && (i.alu[1:0] != 2'b00);
  endfunction

  function automatic bit is_taken(input instr_t i);
    return i.jmp || (i.br && i.zero);
  endfunction

  function automatic instr_t rand_instr();
    instr_t      i;
    logic [31:0] addr;
    int unsigned k;
    i = '0;
    i.pc = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    i.rd = 5'($urandom_range(1, 31));
    i.alu = $urandom;
    i.rs2 = $urandom;
    i.zero = 1'($urandom_range(0, 1));
    addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
    k = $urandom_range(0, 9);
    if (k < 4) begin
      i.rw = 1'b1;
    end else if (k < 6) begin
      i.alu = addr; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1;
    end else if (k < 8) begin
      i.alu = addr; i.mw = 1'b1;
    end else if (k == 8) begin
      i.br = 1'b1;
    end else begin
      i.jmp = 1'b1; i.rw = 1'b1;
    end
    i.stall = ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  task automatic drive(input instr_t i);
    EX_ALU_result = i.alu;   EX_rs2_data = i.rs2;   EX_pc = i.pc;
    EX_rd = i.rd;            EX_zero = i.zero;      EX_branch = i.br;
    EX_unconditional_jmp = i.jmp;                   EX_memread = i.mr;
    EX_memwrite = i.mw;      EX_memtoreg = i.m2r;   EX_regwrite = i.rw;
    EX_stall = i.stall;
  endtask

  // One clock cycle, entered and left at a negative edge.
  task automatic cycle();
    ret_t r;
    mop_t m;
    bit   exp_req, exp_stall, exp_take, ack;
    if (MEM_WB_regwrite === 1'b1) begin
      if (exp_ret.size() == 0) chk("spurious_wb", 32'd1, 32'd0);
      else begin
        r = exp_ret.pop_front();
        chk("wb_result", MEM_WB_result, r.result);
        chk("wb_rd", 32'(MEM_WB_rd), 32'(r.rd));
      end
    end
    chk("misaligned", 32'(MEM_misaligned), 32'(mis_model));
    chk("exmem_rw", 32'(EX_MEM_regwrite), 32'(stg_eff & stg.rw));
    chk("exmem_mr", 32'(EX_MEM_memread), 32'(stg_eff & stg.mr));
    chk("exmem_m2r", 32'(EX_MEM_memtoreg), 32'(stg.m2r));
    chk("exmem_alu", EX_MEM_ALU_result, stg.alu);
    chk("exmem_rd", 32'(EX_MEM_rd), 32'(stg.rd));
    chk("exmem_pc", EX_MEM_pc, stg.pc);

    if (consumed) begin
      if (dq.size() != 0) cur = dq.pop_front();
      else if (nop_fill) cur = '0;
      else cur = rand_instr();
      drive(cur);
    end

    exp_req = stg_eff && (stg.mr || stg.mw) && !is_mis(stg);
    chk("dmem_req", 32'(dmem_bus.dmem_req), 32'(exp_req));
    ack = 1'b0;
    dmem_bus.dmem_rdata = $urandom;
    if (dmem_bus.dmem_req === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        rem = (lq.size() != 0) ? lq.pop_front() : $urandom_range(1, 4);
        exp_wait = exp_wait + 32'(rem - 1);
        hold_addr = dmem_bus.dmem_addr;
        if (exp_mop.size() == 0) chk("spurious_req", 32'd1, 32'd0);
        else begin
          m = exp_mop.pop_front();
          chk("dmem_addr", dmem_bus.dmem_addr, m.addr);
          chk("dmem_we", 32'(dmem_bus.dmem_we), 32'(m.we));
          if (m.we) chk("dmem_wdata", dmem_bus.dmem_wdata, m.wdata);
        end
      end else begin
        chk("addr_hold", dmem_bus.dmem_addr, hold_addr);
      end
      ack = (rem == 1);
      if (ack) begin
        busy = 1'b0;
        if (dmem_bus.dmem_we) resp_mem[dmem_bus.dmem_addr] = dmem_bus.dmem_wdata;
        else dmem_bus.dmem_rdata = resp_read(dmem_bus.dmem_addr);
      end else begin
        rem--;
      end
    end else begin
      busy = 1'b0;
    end
    dmem_bus.dmem_ack = ack;
    #1;
    exp_stall = exp_req && !ack;
    exp_take = stg_eff && is_taken(stg) && !exp_stall;
    chk("mem_stall", 32'(MEM_stall), 32'(exp_stall));
    chk("mem_take", 32'(MEM_take), 32'(exp_take));
    if (stg_eff && is_mis(stg)) mis_model = 1'b1;

    consumed = !exp_stall;
    if (consumed) begin
      stg = cur;
      stg_eff = !cur.stall && !exp_take;
      if (stg_eff) begin
        if ((cur.mr || cur.mw) && !is_mis(cur)) begin
          exp_mop.push_back('{we: cur.mw, addr: cur.alu, wdata: cur.rs2});
          if (cur.mw) model_mem[cur.alu] = cur.rs2;
        end
        if (cur.rw && !is_mis(cur))
          exp_ret.push_back('{result: cur.m2r ? model_read(cur.alu) : cur.alu, rd: cur.rd});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('0);
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stg = '0; stg_eff = 1'b0; consumed = 1'b1; busy = 1'b0;
    mis_model = 1'b0; exp_wait = '0;
    exp_ret.delete(); exp_mop.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_bus.dmem_req), 32'd0);
    chk({tag, "_stall"}, 32'(MEM_stall), 32'd0);
    chk({tag, "_take"}, 32'(MEM_take), 32'd0);
    chk({tag, "_wb_rw"}, 32'(MEM_WB_regwrite), 32'd0);
    chk({tag, "_wb_res"}, MEM_WB_result, 32'd0);
    chk({tag, "_exmem_alu"}, EX_MEM_ALU_result, 32'd0);
    chk({tag, "_exmem_rw"}, 32'(EX_MEM_regwrite), 32'd0);
    chk({tag, "_mis"}, 32'(MEM_misaligned), 32'd0);
    chk({tag, "_wait"}, MEM_wait_cycles, 32'd0);
  endtask

  initial begin
    instr_t i;
    pc_ctr = 32'h1000;
    nop_fill = 1'b1;
    do_reset();
    check_all_zero("reset");

    // Directed scenarios.
    model_mem[32'h40] = 32'hDEADBEEF;
    resp_mem[32'h40]  = 32'hDEADBEEF;
    i = '0; i.alu = 32'h5;  i.rd = 5'd3; i.rw = 1'b1; i.pc = 32'h10; dq.push_back(i);
    i = '0; i.alu = 32'h40; i.rd = 5'd7; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.pc = 32'h14;
    dq.push_back(i); lq.push_back(3);
    i = '0; i.alu = 32'h44; i.rs2 = 32'h1234; i.mw = 1'b1; i.pc = 32'h18;
    dq.push_back(i); lq.push_back(1);
    i = '0; i.alu = 32'h42; i.rd = 5'd9; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.pc = 32'h1C;
    dq.push_back(i);
    i = '0; i.br = 1'b1; i.zero = 1'b1; i.pc = 32'h20; dq.push_back(i);
    i = '0; i.alu = 32'h77; i.rd = 5'd4; i.rw = 1'b1; i.pc = 32'h24; dq.push_back(i);
    i = '0; i.alu = 32'h88; i.rd = 5'd6; i.rw = 1'b1; i.stall = 1'b1; i.pc = 32'h28; dq.push_back(i);
    i = '0; i.alu = 32'h99; i.rd = 5'd5; i.rw = 1'b1; i.pc = 32'h2C; dq.push_back(i);
    repeat (14) cycle();
    chk("dir_wait", MEM_wait_cycles, 32'd2);
    chk("dir_mis_sticky", 32'(MEM_misaligned), 32'd1);
    chk("dir_ret_drained", 32'(exp_ret.size()), 32'd0);
    chk("dir_mop_drained", 32'(exp_mop.size()), 32'd0);

    // Random instruction stream, then drain with NOPs.
    nop_fill = 1'b0;
    repeat (400) cycle();
    nop_fill = 1'b1;
    repeat (20) cycle();
    chk("rand_wait", MEM_wait_cycles, exp_wait);
    chk("rand_ret_drained", 32'(exp_ret.size()), 32'd0);
    chk("rand_mop_drained", 32'(exp_mop.size()), 32'd0);

    // Reset while a slow load is outstanding; a late ack must be ignored.
    i = '0; i.alu = 32'h104; i.rd = 5'd8; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1;
    dq.push_back(i); lq.push_back(6);
    repeat (3) cycle();
    chk("pre_rst_stall", 32'(MEM_stall), 32'd1);
    rst = 1'b1;
    drive('0);
    dmem_bus.dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("late_ack");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
